exe_stage: RTL

//  Execute stage of the 5-stage ARM pipeline; consumes the ID/EX register outputs.

---
 rtl/exe_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline: operand forwarding, Val2 generation,
// ALU with NZCV status register, branch target adder and the EX/MEM pipeline register.
module exe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          freeze,
  input  logic          wb_en,
  input  logic          mem_r_en,
  input  logic          mem_w_en,
  input  logic          b,
  input  logic          s,
  input  logic          imm,
  input  logic [3:0]    exe_cmd,
  input  logic [3:0]    dest,
  input  logic [11:0]   shift_operand,
  input  logic [23:0]   signed_imm_24,
  input  logic [DW-1:0] pc,
  input  logic [DW-1:0] val_rn,
  input  logic [DW-1:0] val_rm,
  input  logic [1:0]    fwd_sel1,
  input  logic [1:0]    fwd_sel2,
  input  logic [DW-1:0] mem_fwd,
  input  logic [DW-1:0] wb_fwd,
  output logic [3:0]    sr,
  output logic          branch_taken,
  output logic [DW-1:0] branch_addr,
  output logic          wb_en_o,
  output logic          mem_r_en_o,
  output logic          mem_w_en_o,
  output logic [DW-1:0] alu_res_o,
  output logic [DW-1:0] st_val_o,
  output logic [3:0]    dest_o
);

  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_rm;
  logic [DW-1:0] w_val2;
  logic [DW-1:0] w_b;
  logic          w_cin;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_res;
  logic          w_arith;
  logic          w_valid;
  logic          w_v;
  logic [3:0]    w_flags;

  logic [3:0]    r_sr;
  logic          r_wb_en;
  logic          r_mem_r_en;
  logic          r_mem_w_en;
  logic [DW-1:0] r_alu_res;
  logic [DW-1:0] r_st_val;
  logic [3:0]    r_dest;

  function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input logic [4:0] n);
    if (n == 5'd0) return x;
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  always_comb begin
    unique case (fwd_sel1)
      2'b01:   w_op1 = mem_fwd;
      2'b10:   w_op1 = wb_fwd;
      default: w_op1 = val_rn;
    endcase
    unique case (fwd_sel2)
      2'b01:   w_rm = mem_fwd;
      2'b10:   w_rm = wb_fwd;
      default: w_rm = val_rm;
    endcase
  end

  always_comb begin
    w_val2 = w_rm;
    if (mem_r_en || mem_w_en) begin
      w_val2 = {20'b0, shift_operand};
    end else if (imm) begin
      w_val2 = ror({24'b0, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    end else if (shift_operand[11:7] != 5'd0) begin
      unique case (shift_operand[6:5])
        2'b00: w_val2 = w_rm << shift_operand[11:7];
        2'b01: w_val2 = w_rm >> shift_operand[11:7];
        2'b10: w_val2 = DW'($signed(w_rm) >>> shift_operand[11:7]);
        2'b11: w_val2 = ror(w_rm, shift_operand[11:7]);
      endcase
    end
  end

  // Add and subtract share one adder: subtraction is Op1 + ~Val2 + cin, so the
  // adder carry-out is directly the ARM "no borrow" C flag.
  always_comb begin
    w_b   = w_val2;
    w_cin = 1'b0;
    unique case (exe_cmd)
      4'h3:    w_cin = r_sr[1];
      4'h4:    begin w_b = ~w_val2; w_cin = 1'b1;    end
      4'h5:    begin w_b = ~w_val2; w_cin = r_sr[1]; end
      default: ;
    endcase
    w_sum = {1'b0, w_op1} + {1'b0, w_b} + {{DW{1'b0}}, w_cin};
    w_v   = (w_op1[DW-1] == w_b[DW-1]) && (w_sum[DW-1] != w_op1[DW-1]);
  end

  always_comb begin
    w_res   = '0;
    w_arith = 1'b0;
    w_valid = 1'b1;
    unique case (exe_cmd)
      4'h1:                   w_res = w_val2;
      4'h9:                   w_res = ~w_val2;
      4'h2, 4'h3, 4'h4, 4'h5: begin w_res = w_sum[DW-1:0]; w_arith = 1'b1; end
      4'h6:                   w_res = w_op1 & w_val2;
      4'h7:                   w_res = w_op1 | w_val2;
      4'h8:                   w_res = w_op1 ^ w_val2;
      default:                w_valid = 1'b0;
    endcase
    w_flags = {w_res[DW-1], (w_res == '0),
               w_arith ? w_sum[DW] : r_sr[1],
               w_arith ? w_v       : r_sr[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_alu_res  <= '0;
      r_st_val   <= '0;
      r_dest     <= '0;
    end else if (!freeze) begin
      if (s && w_valid) r_sr <= w_flags;
      r_wb_en    <= wb_en;
      r_mem_r_en <= mem_r_en;
      r_mem_w_en <= mem_w_en;
      r_alu_res  <= w_res;
      r_st_val   <= w_rm;
      r_dest     <= dest;
    end
  end

  assign branch_taken = b;
  assign branch_addr  = pc + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign sr           = r_sr;
  assign wb_en_o      = r_wb_en;
  assign mem_r_en_o   = r_mem_r_en;
  assign mem_w_en_o   = r_mem_w_en;
  assign alu_res_o    = r_alu_res;
  assign st_val_o     = r_st_val;
  assign dest_o       = r_dest;

endmodule
